// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: pipeline status in, stall/flush/PC/trap control out
interface pipeline_hazard_ctrl_if #(
    parameter int NUM_STAGES = 3
);
    logic                  iren;
    logic                  i_mem_busy;
    logic                  dren;
    logic                  dwen;
    logic                  d_mem_busy;
    logic                  mispredict;
    logic [31:0]           redirect_pc;
    logic                  token_ex;
    logic                  fault_insn;
    logic                  mal_insn;
    logic [31:0]           epc_f;
    logic [31:0]           badaddr_f;
    logic                  illegal_insn;
    logic                  breakpoint;
    logic                  env_m;
    logic                  mal_l;
    logic                  fault_l;
    logic                  mal_s;
    logic                  fault_s;
    logic [31:0]           epc_e;
    logic [31:0]           badaddr_e;
    logic                  ret;
    logic                  halt;
    logic [31:0]           tvec;
    logic [31:0]           mepc;
    logic                  pc_en;
    logic                  npc_sel;
    logic [31:0]           npc_out;
    logic [NUM_STAGES-2:0] stall;
    logic [NUM_STAGES-2:0] flush;
    logic                  insert_priv_pc;
    logic [31:0]           priv_pc;
    logic                  trap_valid;
    logic [3:0]            trap_cause;
    logic [31:0]           trap_epc;
    logic [31:0]           trap_badaddr;
    logic                  halted;

    modport master (
        output iren, i_mem_busy, dren, dwen, d_mem_busy, mispredict, redirect_pc,
               token_ex, fault_insn, mal_insn, epc_f, badaddr_f,
               illegal_insn, breakpoint, env_m, mal_l, fault_l, mal_s, fault_s,
               epc_e, badaddr_e, ret, halt, tvec, mepc,
        input  pc_en, npc_sel, npc_out, stall, flush, insert_priv_pc, priv_pc,
               trap_valid, trap_cause, trap_epc, trap_badaddr, halted
    );

    modport slave (
        input  iren, i_mem_busy, dren, dwen, d_mem_busy, mispredict, redirect_pc,
               token_ex, fault_insn, mal_insn, epc_f, badaddr_f,
               illegal_insn, breakpoint, env_m, mal_l, fault_l, mal_s, fault_s,
               epc_e, badaddr_e, ret, halt, tvec, mepc,
        output pc_en, npc_sel, npc_out, stall, flush, insert_priv_pc, priv_pc,
               trap_valid, trap_cause, trap_epc, trap_badaddr, halted
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/redirect and trap/return/halt sequencing for an in-order pipeline
module pipeline_hazard_ctrl #(
    parameter int NUM_STAGES    = 3,
    parameter int RESOLVE_STAGE = 1
) (
    input logic                   CLK,
    input logic                   RST,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int W = NUM_STAGES - 1;
    localparam logic [W-1:0] ALL = '1;
    localparam logic [W-1:0] RES_MASK = ALL >> (W - RESOLVE_STAGE);
    localparam logic [W-1:0] F0 = W'(1);

    typedef enum logic [1:0] {RUN, DRAIN, TRAP, HALT} state_t;

    state_t      state, state_n;
    logic [W-1:0] vld, vld_n, stall, flush;
    logic        redir_pend, redir_pend_n, fpend, fpend_n, is_ret, is_ret_n;
    logic [31:0] redir_pc, redir_pc_n, ret_pc, ret_pc_n, target;
    logic [3:0]  cause, cause_n, exc_cause;
    logic [31:0] epc, epc_n, bad, bad_n;
    logic        pc_en, npc_sel, insert, trap_valid, commit_exc, fetch_exc, fetch_in;
    logic        unused_ok;

    assign unused_ok  = &{1'b0, hz.dren, hz.dwen};
    assign commit_exc = hz.token_ex & |{hz.illegal_insn, hz.breakpoint, hz.env_m,
                                        hz.mal_l, hz.fault_l, hz.mal_s, hz.fault_s};
    assign exc_cause  = hz.illegal_insn ? 4'd2 : hz.breakpoint ? 4'd3 : hz.env_m ? 4'd11 :
                        hz.mal_l ? 4'd4 : hz.mal_s ? 4'd6 : hz.fault_l ? 4'd5 : 4'd7;
    assign fetch_exc  = (hz.fault_insn | hz.mal_insn) & !hz.i_mem_busy;
    assign target     = redir_pend ? redir_pc : hz.redirect_pc;
    assign fetch_in   = hz.iren & !hz.i_mem_busy & pc_en;

    // Control decode and next-state for FSM, pending redirect and trap record
    always_comb begin
        state_n      = state;
        pc_en        = 1'b0;
        npc_sel      = 1'b0;
        stall        = '0;
        flush        = '0;
        insert       = 1'b0;
        trap_valid   = 1'b0;
        redir_pend_n = redir_pend;
        redir_pc_n   = redir_pc;
        fpend_n      = fpend;
        is_ret_n     = is_ret;
        ret_pc_n     = ret_pc;
        cause_n      = cause;
        epc_n        = epc;
        bad_n        = bad;
        case (state)
            RUN: begin
                if (commit_exc) begin
                    flush        = ALL;
                    state_n      = DRAIN;
                    fpend_n      = 1'b0;
                    redir_pend_n = 1'b0;
                    is_ret_n     = 1'b0;
                    cause_n      = exc_cause;
                    epc_n        = hz.epc_e;
                    bad_n        = (exc_cause[3:2] == 2'b01) ? hz.badaddr_e : '0;
                end else if (hz.ret && hz.token_ex) begin
                    flush        = ALL;
                    state_n      = DRAIN;
                    fpend_n      = 1'b0;
                    redir_pend_n = 1'b0;
                    is_ret_n     = 1'b1;
                    ret_pc_n     = hz.mepc;
                end else if (hz.halt && hz.token_ex && !hz.d_mem_busy) begin
                    flush        = ALL;
                    state_n      = HALT;
                    fpend_n      = 1'b0;
                    redir_pend_n = 1'b0;
                end else if (hz.d_mem_busy) begin
                    stall = ALL;
                    if (hz.mispredict && !redir_pend) begin
                        redir_pend_n = 1'b1;
                        redir_pc_n   = hz.redirect_pc;
                    end
                end else if (hz.mispredict || redir_pend) begin
                    // a redirect squashes any younger faulting fetch as well
                    flush        = RES_MASK;
                    fpend_n      = 1'b0;
                    redir_pc_n   = target;
                    pc_en        = !hz.i_mem_busy;
                    npc_sel      = !hz.i_mem_busy;
                    redir_pend_n = hz.i_mem_busy;
                end else if (fpend) begin
                    flush = F0;
                    if (vld == '0) begin
                        trap_valid = 1'b1;
                        state_n    = TRAP;
                        fpend_n    = 1'b0;
                    end
                end else if (fetch_exc) begin
                    flush    = F0;
                    fpend_n  = 1'b1;
                    is_ret_n = 1'b0;
                    cause_n  = hz.fault_insn ? 4'd1 : 4'd0;
                    epc_n    = hz.epc_f;
                    bad_n    = hz.badaddr_f;
                end else if (hz.i_mem_busy) begin
                    flush = F0;
                end else begin
                    pc_en = 1'b1;
                end
            end
            DRAIN: begin
                flush = F0;
                if (!hz.d_mem_busy) begin
                    trap_valid = !is_ret;
                    state_n    = TRAP;
                end
            end
            TRAP: begin
                insert  = 1'b1;
                pc_en   = 1'b1;
                flush   = ALL;
                state_n = RUN;
            end
            default: flush = F0;
        endcase
        if (RST) begin
            pc_en      = 1'b0;
            npc_sel    = 1'b0;
            stall      = '0;
            flush      = '0;
            insert     = 1'b0;
            trap_valid = 1'b0;
        end
    end

    // Occupancy of each pipeline register follows its stall/flush/advance
    always_comb begin
        vld_n = vld;
        for (int k = 0; k < W; k++)
            vld_n[k] = stall[k] ? vld[k] : flush[k] ? 1'b0 :
                       (k == 0) ? fetch_in : vld[(k == 0) ? 0 : k - 1];
    end

    // State, occupancy, pending redirect and trap record registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= RUN;
            vld        <= '0;
            redir_pend <= 1'b0;
            redir_pc   <= '0;
            fpend      <= 1'b0;
            is_ret     <= 1'b0;
            ret_pc     <= '0;
            cause      <= '0;
            epc        <= '0;
            bad        <= '0;
        end else begin
            state      <= state_n;
            vld        <= vld_n;
            redir_pend <= redir_pend_n;
            redir_pc   <= redir_pc_n;
            fpend      <= fpend_n;
            is_ret     <= is_ret_n;
            ret_pc     <= ret_pc_n;
            cause      <= cause_n;
            epc        <= epc_n;
            bad        <= bad_n;
        end
    end

    assign hz.pc_en          = pc_en;
    assign hz.npc_sel        = npc_sel;
    assign hz.npc_out        = npc_sel ? target : '0;
    assign hz.stall          = stall;
    assign hz.flush          = flush;
    assign hz.insert_priv_pc = insert;
    assign hz.priv_pc        = insert ? (is_ret ? ret_pc : hz.tvec) : '0;
    assign hz.trap_valid     = trap_valid;
    assign hz.trap_cause     = cause;
    assign hz.trap_epc       = epc;
    assign hz.trap_badaddr   = bad;
    assign hz.halted         = (state == HALT) & !RST;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vectors and multi-cycle sequences for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
    logic CLK = 1'b0;
    logic RST;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    pipeline_hazard_ctrl_if #(.NUM_STAGES(3)) hz();

    pipeline_hazard_ctrl #(.NUM_STAGES(3), .RESOLVE_STAGE(1)) dut (
        .CLK(CLK),
        .RST(RST),
        .hz (hz)
    );

    // in: {iren, i_mem_busy, d_mem_busy, mispredict, token_ex, ret, halt, fault_insn}
    // exc: {illegal, breakpoint, env_m, mal_l, mal_s, fault_l, fault_s}
    // ctl: {pc_en, npc_sel, stall[1:0], flush[1:0]}
    typedef struct {
        string       name;
        logic [7:0]  in;
        logic [6:0]  exc;
        logic [31:0] rpc;
        logic [5:0]  ctl;
        logic [31:0] npc;
        logic        tr;
        logic [3:0]  cause;
        logic [31:0] bad;
    } vec_t;

    vec_t v[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic ctl(input string name, input logic [5:0] exp);
        chk(name, {26'b0, hz.pc_en, hz.npc_sel, hz.stall, hz.flush}, {26'b0, exp});
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_in;
        {hz.iren, hz.i_mem_busy, hz.dren, hz.dwen, hz.d_mem_busy, hz.mispredict} = '0;
        {hz.token_ex, hz.fault_insn, hz.mal_insn, hz.ret, hz.halt} = '0;
        {hz.illegal_insn, hz.breakpoint, hz.env_m, hz.mal_l, hz.mal_s, hz.fault_l, hz.fault_s} = '0;
        hz.redirect_pc = '0;
        hz.epc_f       = '0;
        hz.badaddr_f   = '0;
        hz.epc_e       = '0;
        hz.badaddr_e   = '0;
        hz.tvec        = 32'hA000;
        hz.mepc        = 32'h3000;
    endtask

    task automatic do_reset;
        RST = 1'b1;
        clear_in();
        tick();
        RST = 1'b0;
    endtask

    task automatic fill_pipe;
        hz.iren = 1'b1;
        tick();
        tick();
        chk("fill_vld", {30'b0, dut.vld}, 32'h3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        v[0]  = '{"idle",            8'b1000_0000, 7'b0000000, 32'h0,   6'b10_00_00, 32'h0,   1'b0, 4'd0,  32'h0};
        v[1]  = '{"mispredict",      8'b1001_0000, 7'b0000000, 32'h200, 6'b11_00_01, 32'h200, 1'b0, 4'd0,  32'h0};
        v[2]  = '{"mis_ibusy",       8'b1101_0000, 7'b0000000, 32'h200, 6'b00_00_01, 32'h0,   1'b0, 4'd0,  32'h0};
        v[3]  = '{"ibusy",           8'b1100_0000, 7'b0000000, 32'h0,   6'b00_00_01, 32'h0,   1'b0, 4'd0,  32'h0};
        v[4]  = '{"dbusy",           8'b1010_0000, 7'b0000000, 32'h0,   6'b00_11_00, 32'h0,   1'b0, 4'd0,  32'h0};
        v[5]  = '{"dbusy_mis",       8'b1011_0000, 7'b0000000, 32'h200, 6'b00_11_00, 32'h0,   1'b0, 4'd0,  32'h0};
        v[6]  = '{"illegal_mal_l",   8'b0000_1000, 7'b1001000, 32'h0,   6'b00_00_11, 32'h0,   1'b1, 4'd2,  32'h0};
        v[7]  = '{"bp_env",          8'b0000_1000, 7'b0110000, 32'h0,   6'b00_00_11, 32'h0,   1'b1, 4'd3,  32'h0};
        v[8]  = '{"env_mal_l",       8'b0000_1000, 7'b0011000, 32'h0,   6'b00_00_11, 32'h0,   1'b1, 4'd11, 32'h0};
        v[9]  = '{"mal_l_mal_s",     8'b0000_1000, 7'b0001100, 32'h0,   6'b00_00_11, 32'h0,   1'b1, 4'd4,  32'hBAD0};
        v[10] = '{"mal_s_fault_l",   8'b0000_1000, 7'b0000110, 32'h0,   6'b00_00_11, 32'h0,   1'b1, 4'd6,  32'hBAD0};
        v[11] = '{"fault_l_fault_s", 8'b0000_1000, 7'b0000011, 32'h0,   6'b00_00_11, 32'h0,   1'b1, 4'd5,  32'hBAD0};
        v[12] = '{"fault_s_dbusy",   8'b0010_1000, 7'b0000001, 32'h0,   6'b00_00_11, 32'h0,   1'b1, 4'd7,  32'hBAD0};
        v[13] = '{"exc_no_token",    8'b1000_0000, 7'b1000000, 32'h0,   6'b10_00_00, 32'h0,   1'b0, 4'd0,  32'h0};
        v[14] = '{"ret",             8'b0000_1100, 7'b0000000, 32'h0,   6'b00_00_11, 32'h0,   1'b0, 4'd0,  32'h0};
        v[15] = '{"halt",            8'b0000_1010, 7'b0000000, 32'h0,   6'b00_00_11, 32'h0,   1'b0, 4'd0,  32'h0};
        v[16] = '{"halt_dbusy",      8'b0010_1010, 7'b0000000, 32'h0,   6'b00_11_00, 32'h0,   1'b0, 4'd0,  32'h0};
        v[17] = '{"fetch_fault",     8'b1000_0001, 7'b0000000, 32'h0,   6'b00_00_01, 32'h0,   1'b0, 4'd0,  32'h0};
        v[18] = '{"mis_over_fault",  8'b1001_0001, 7'b0000000, 32'h340, 6'b11_00_01, 32'h340, 1'b0, 4'd0,  32'h0};

        RST = 1'b1;
        clear_in();
        hz.iren = 1'b1;
        #2;
        ctl("rst_ctl", 6'b00_00_00);
        chk("rst_halted", {31'b0, hz.halted}, 32'h0);
        chk("rst_insert", {31'b0, hz.insert_priv_pc}, 32'h0);
        tick();
        chk("rst_cause", {28'b0, hz.trap_cause}, 32'h0);
        chk("rst_epc", hz.trap_epc, 32'h0);
        chk("rst_vld", {30'b0, dut.vld}, 32'h0);

        for (int i = 0; i < 19; i++) begin
            do_reset();
            {hz.iren, hz.i_mem_busy, hz.d_mem_busy, hz.mispredict,
             hz.token_ex, hz.ret, hz.halt, hz.fault_insn} = v[i].in;
            {hz.illegal_insn, hz.breakpoint, hz.env_m, hz.mal_l,
             hz.mal_s, hz.fault_l, hz.fault_s} = v[i].exc;
            hz.redirect_pc = v[i].rpc;
            hz.epc_e       = 32'h80;
            hz.badaddr_e   = 32'hBAD0;
            #1;
            ctl({v[i].name, "_ctl"}, v[i].ctl);
            chk({v[i].name, "_npc"}, hz.npc_out, v[i].npc);
            if (v[i].tr) begin
                tick();
                chk({v[i].name, "_cause"}, {28'b0, hz.trap_cause}, {28'b0, v[i].cause});
                chk({v[i].name, "_epc"}, hz.trap_epc, 32'h80);
                chk({v[i].name, "_bad"}, hz.trap_badaddr, v[i].bad);
            end
        end

        // mispredict held off by a busy instruction memory
        do_reset();
        hz.mispredict  = 1'b1;
        hz.redirect_pc = 32'h200;
        hz.i_mem_busy  = 1'b1;
        #1;
        ctl("redir_wait0", 6'b00_00_01);
        tick();
        hz.mispredict  = 1'b0;
        hz.redirect_pc = 32'h999;
        #1;
        ctl("redir_wait1", 6'b00_00_01);
        tick();
        ctl("redir_wait2", 6'b00_00_01);
        tick();
        hz.i_mem_busy = 1'b0;
        #1;
        ctl("redir_go", 6'b11_00_01);
        chk("redir_go_npc", hz.npc_out, 32'h200);
        tick();
        ctl("redir_done", 6'b10_00_00);

        // data memory busy freezes a full pipe
        do_reset();
        fill_pipe();
        hz.d_mem_busy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            ctl("dbusy_ctl", 6'b00_11_00);
            tick();
            chk("dbusy_vld", {30'b0, dut.vld}, 32'h3);
        end
        hz.d_mem_busy = 1'b0;
        #1;
        ctl("dbusy_release", 6'b10_00_00);
        tick();
        chk("dbusy_rel_vld", {30'b0, dut.vld}, 32'h3);

        // commit exception drains behind a busy data memory
        do_reset();
        hz.token_ex     = 1'b1;
        hz.illegal_insn = 1'b1;
        hz.mal_l        = 1'b1;
        hz.epc_e        = 32'h80;
        hz.badaddr_e    = 32'h55;
        hz.d_mem_busy   = 1'b1;
        #1;
        ctl("cexc_entry", 6'b00_00_11);
        tick();
        {hz.token_ex, hz.illegal_insn, hz.mal_l} = '0;
        #1;
        ctl("cexc_drain1", 6'b00_00_01);
        chk("cexc_drain1_tv", {31'b0, hz.trap_valid}, 32'h0);
        tick();
        hz.d_mem_busy = 1'b0;
        #1;
        chk("cexc_tv", {31'b0, hz.trap_valid}, 32'h1);
        chk("cexc_cause", {28'b0, hz.trap_cause}, 32'd2);
        chk("cexc_epc", hz.trap_epc, 32'h80);
        chk("cexc_bad", hz.trap_badaddr, 32'h0);
        tick();
        chk("cexc_insert", {31'b0, hz.insert_priv_pc}, 32'h1);
        chk("cexc_priv_pc", hz.priv_pc, 32'hA000);
        ctl("cexc_trap_ctl", 6'b10_00_11);
        chk("cexc_trap_tv", {31'b0, hz.trap_valid}, 32'h0);
        tick();
        chk("cexc_run_insert", {31'b0, hz.insert_priv_pc}, 32'h0);
        chk("cexc_hold_cause", {28'b0, hz.trap_cause}, 32'd2);

        // fetch fault waits for older instructions to leave the pipe
        do_reset();
        fill_pipe();
        hz.fault_insn = 1'b1;
        hz.epc_f      = 32'h104;
        hz.badaddr_f  = 32'h106;
        #1;
        ctl("ffault_a", 6'b00_00_01);
        tick();
        chk("ffault_vld_a", {30'b0, dut.vld}, 32'h2);
        ctl("ffault_b", 6'b00_00_01);
        chk("ffault_b_tv", {31'b0, hz.trap_valid}, 32'h0);
        tick();
        chk("ffault_vld_b", {30'b0, dut.vld}, 32'h0);
        hz.fault_insn = 1'b0;
        #1;
        chk("ffault_tv", {31'b0, hz.trap_valid}, 32'h1);
        chk("ffault_cause", {28'b0, hz.trap_cause}, 32'd1);
        chk("ffault_epc", hz.trap_epc, 32'h104);
        chk("ffault_bad", hz.trap_badaddr, 32'h106);
        tick();
        chk("ffault_insert", {31'b0, hz.insert_priv_pc}, 32'h1);
        chk("ffault_priv_pc", hz.priv_pc, 32'hA000);
        tick();
        ctl("ffault_resume", 6'b10_00_00);

        // commit exception during the fetch-fault wait discards the fetch record
        do_reset();
        fill_pipe();
        hz.fault_insn = 1'b1;
        hz.epc_f      = 32'h104;
        #1;
        ctl("fdrop_a", 6'b00_00_01);
        tick();
        hz.fault_insn = 1'b0;
        hz.token_ex   = 1'b1;
        hz.env_m      = 1'b1;
        hz.epc_e      = 32'h300;
        #1;
        ctl("fdrop_cexc", 6'b00_00_11);
        tick();
        {hz.token_ex, hz.env_m} = '0;
        #1;
        chk("fdrop_tv", {31'b0, hz.trap_valid}, 32'h1);
        chk("fdrop_cause", {28'b0, hz.trap_cause}, 32'd11);
        chk("fdrop_epc", hz.trap_epc, 32'h300);
        tick();
        chk("fdrop_insert", {31'b0, hz.insert_priv_pc}, 32'h1);
        tick();
        chk("fdrop_run_tv", {31'b0, hz.trap_valid}, 32'h0);
        ctl("fdrop_run_ctl", 6'b10_00_00);
        tick();
        chk("fdrop_run2_tv", {31'b0, hz.trap_valid}, 32'h0);

        // MRET returns to mepc without a trap strobe
        do_reset();
        hz.token_ex = 1'b1;
        hz.ret      = 1'b1;
        hz.mepc     = 32'h3000;
        tick();
        {hz.token_ex, hz.ret} = '0;
        hz.mepc = 32'h7777;
        #1;
        chk("ret_drain_tv", {31'b0, hz.trap_valid}, 32'h0);
        tick();
        chk("ret_insert", {31'b0, hz.insert_priv_pc}, 32'h1);
        chk("ret_priv_pc", hz.priv_pc, 32'h3000);

        // halt is sticky until reset
        do_reset();
        hz.token_ex = 1'b1;
        hz.halt     = 1'b1;
        #1;
        ctl("halt_entry", 6'b00_00_11);
        chk("halt_entry_halted", {31'b0, hz.halted}, 32'h0);
        tick();
        clear_in();
        hz.iren        = 1'b1;
        hz.mispredict  = 1'b1;
        hz.redirect_pc = 32'h200;
        #1;
        chk("halt_halted", {31'b0, hz.halted}, 32'h1);
        ctl("halt_ctl", 6'b00_00_01);
        tick();
        tick();
        chk("halt_sticky", {31'b0, hz.halted}, 32'h1);
        ctl("halt_sticky_ctl", 6'b00_00_01);
        RST = 1'b1;
        #1;
        ctl("halt_rst_ctl", 6'b00_00_00);
        chk("halt_rst_halted", {31'b0, hz.halted}, 32'h0);
        tick();
        RST = 1'b0;
        clear_in();
        hz.iren = 1'b1;
        #1;
        chk("post_rst_halted", {31'b0, hz.halted}, 32'h0);
        ctl("post_rst_ctl", 6'b10_00_00);
        chk("post_rst_cause", {28'b0, hz.trap_cause}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
